fwd_unit: RTL
=============

# fwd_unit

Data-forwarding unit for the five-stage pipeline; it is the bypass-side counterpart of the load-use bubble logic. It tracks the destination register of every in-flight instruction through EX, MEM and WB in its own shadow pipeline. Each cycle it selects, for both EX-stage operands, the newest produced value: EX/MEM ALU result, MEM/WB write-back data, or the register-file value. It consumes the bubble/flush indications from ID so that bubbled or flushed slots never forward.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- CLK  in  1  pipeline clock, rising-edge
- RSTn  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction leaving ID is real; 0 = bubble inserted into EX
- clear  in  1  flush; slot entering EX on next edge is invalidated
- id_rs1, id_rs2  in  RA_W  source registers of instruction leaving ID
- id_rd  in  RA_W  destination register of instruction leaving ID
- id_regwrite  in  1  instruction leaving ID writes rd
- id_memread  in  1  instruction leaving ID is a load (opcode 7'b0000011)
- ex_rs1_data, ex_rs2_data  in  XLEN  register-file operands held in ID/EX
- mem_alu_result  in  XLEN  ALU result held in EX/MEM
- wb_data  in  XLEN  final write-back value held in MEM/WB
- fwd_a, fwd_b  out  2  select: 2'b00 regfile, 2'b10 MEM, 2'b01 WB
- operand_a, operand_b  out  XLEN  forwarded EX operands
- load_use_err  out  1  sticky: un-stalled load-use detected

## Operation
- Shadow entries EX, MEM, WB, each {valid, rd, regwrite, memread}; EX also holds rs1, rs2.
- Every rising CLK edge, the shadow pipeline shifts: WB<=MEM, MEM<=EX, EX<=ID inputs. There is no stall of EX and later stages. ID holds are expressed as id_valid=0.
- EX.valid <= id_valid & ~clear. clear has priority over id_valid. MEM and WB are not affected by clear.
- An entry is a forwarding source when it is valid, has regwrite=1, and has rd != 0.
- fwd_a is 2'b10 when MEM is a source, MEM.memread=0, and MEM.rd == EX.rs1.
- Otherwise, fwd_a is 2'b01 when WB is a source and WB.rd == EX.rs1.
- Otherwise, fwd_a is 2'b00. fwd_b follows the same rules using EX.rs2.
- MEM has priority over WB when both match, because MEM holds the newer producer.
- A load in MEM is never a forwarding source, since its data is not ready. Selection then falls through to WB or to the register file.
- If EX is invalid, fwd_a and fwd_b are 2'b00.
- operand_x = ex_rsx_data / mem_alu_result / wb_data according to fwd_x. This is combinational from the registered state and data inputs.
- Register x0 is never forwarded, even when an entry writes rd=0.

## Timing
- Reset (RSTn=0, asynchronous): all entries valid=0, and all rd/rs fields and flags are 0. fwd_a and fwd_b are 2'b00, operand_x = ex_rsx_data, and load_use_err=0.
- Release of reset is synchronous to CLK. The first edge after release loads EX from the ID inputs.
- Zero-cycle latency: fwd_x is valid in the same cycle the instruction sits in EX.
- Back-to-back dependent ALU ops use MEM forwarding, with no stall.
- A dependence at distance 2 uses WB forwarding.
- A dependence at distance 3 or more uses the register file. The register file is write-before-read and is outside this block.
- Load followed by a dependent instruction: the bubble logic keeps the consumer in ID for one cycle and sends id_valid=0. The consumer then reaches EX while the load is in WB, giving fwd=2'b01.
- Reset asserted mid-operation: all entries are invalidated immediately, with no partial shift.

## Configuration
- LOAD_USE_CHECK_EN is defined: each cycle, if EX is valid, MEM is a source, MEM.memread=1, and MEM.rd matches EX.rs1 or EX.rs2, then load_use_err is set at the next edge. It stays set until RSTn=0.
- LOAD_USE_CHECK_EN is undefined: load_use_err is tied to 0 and no check logic is built.
- Forwarding behaviour is identical in both builds.

## Structure
- A shared package holds:
  - the fwd select constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
  - the OP_LOAD=7'b0000011 constant;
  - the shadow-entry struct typedef.
- One sub-module, fwd_sel, is instantiated twice, once per operand. It takes the EX source register and the MEM/WB entries and produces the 2-bit select. The top level holds the shadow registers and the operand muxes.

## Test plan
- add x5 then sub x6,x5,x1 back-to-back, mem_alu_result=32'h1234 -> fwd_a=2'b10, operand_a=32'h1234.
- addi x7 at distance 2, consumer uses x7 as rs2, wb_data=32'hBEEF -> fwd_b=2'b01, operand_b=32'hBEEF.
- x3 written in MEM (=32'h11) and in WB (=32'h22), consumer reads x3 -> fwd_a=2'b10, operand_a=32'h11.
- Producer writes x0 (rd=0, regwrite=1), next instruction reads x0 -> fwd_a=2'b00, operand_a=ex_rs1_data.
- lw x9, then bubble (id_valid=0), then add uses x9 -> in its EX cycle fwd_a=2'b01, and load_use_err stays 0.
- With LOAD_USE_CHECK_EN: lw x9 followed directly by add x10,x9,x9 with no bubble -> fwd_a=2'b00 and load_use_err=1 one edge later and held. Asserting RSTn=0 -> load_use_err=0 immediately.

Source files
------------

// File: rtl/fwd_unit_pkg.sv
// rtl/fwd_unit_pkg.sv - shared constants, shadow-entry type and source test for fwd_unit
package fwd_unit_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } shadow_t;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value
  function automatic logic is_source(input shadow_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_unit_fwd_sel.sv
// rtl/fwd_unit_fwd_sel.sv - per-operand forward select: MEM beats WB, loads in MEM never forward
module fwd_sel
  import fwd_unit_pkg::*;
(
  input  logic            ex_valid,
  input  logic [RA_W-1:0] rs,
  input  shadow_t         mem,
  input  shadow_t         wb,
  output logic [1:0]      sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_valid) begin
      if (is_source(mem) && !mem.memread && (mem.rd == rs))
        sel = FWD_MEM;
      else if (is_source(wb) && (wb.rd == rs))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - EX operand bypass with EX/MEM/WB shadow pipeline; LOAD_USE_CHECK_EN adds sticky load-use flag
module fwd_unit
  import fwd_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            id_valid,
  input  logic            clear,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] wb_data,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic            load_use_err
);

  shadow_t         ex_q, mem_q, wb_q;
  logic [RA_W-1:0] ex_rs1_q, ex_rs2_q;

  // EX and later never stall, so the shadow pipeline shifts unconditionally
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      ex_q     <= '{valid: id_valid & ~clear, rd: id_rd,
                    regwrite: id_regwrite, memread: id_memread};
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      ex_rs1_q <= id_rs1;
      ex_rs2_q <= id_rs2;
    end
  end

  fwd_sel u_sel_a (
    .ex_valid (ex_q.valid),
    .rs       (ex_rs1_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_a)
  );

  fwd_sel u_sel_b (
    .ex_valid (ex_q.valid),
    .rs       (ex_rs2_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_b)
  );

  always_comb begin
    case (fwd_a)
      FWD_MEM: operand_a = mem_alu_result;
      FWD_WB:  operand_a = wb_data;
      default: operand_a = ex_rs1_data;
    endcase
    case (fwd_b)
      FWD_MEM: operand_b = mem_alu_result;
      FWD_WB:  operand_b = wb_data;
      default: operand_b = ex_rs2_data;
    endcase
  end

`ifdef LOAD_USE_CHECK_EN
  logic lu_hit;

  // a dependent instruction directly behind a load means the bubble logic failed to stall
  assign lu_hit = ex_q.valid && is_source(mem_q) && mem_q.memread &&
                  ((mem_q.rd == ex_rs1_q) || (mem_q.rd == ex_rs2_q));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      load_use_err <= 1'b0;
    else if (lu_hit)
      load_use_err <= 1'b1;
  end
`else
  assign load_use_err = 1'b0;
`endif

endmodule
